flashemu_mio: RTL and testbench



---
 rtl/flashemu_mio.sv | 252 +++++++++++++++++++++++++
 tb/tb_flashemu_mio.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flashemu_mio.sv
// SPI NOR flash emulator: oversampled SPI pins, single/dual/quad reads and
// JEDEC ID, served from a byte-wide memory port with a one-byte prefetch.
module flashemu_mio #(
    parameter int          AW       = 16,
    parameter int          DUMMY    = 8,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spi_clk,
    input  logic          spi_cs_n,
    input  logic [3:0]    spi_io_di,
    output logic [3:0]    spi_io_do,
    output logic [3:0]    spi_io_oe,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_ID,
        S_IGNORE
    } state_t;

    typedef enum logic [1:0] {
        LANE_1,
        LANE_2,
        LANE_4
    } lanes_t;

    localparam logic [5:0] DUMMY_LAST = 6'(DUMMY - 1);

    logic [1:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] io0_sync;
    logic       sclk_d;
    logic       cs_d;

    // CS flops reset low so a frame already running at reset release can
    // never look like a fresh CS falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            io0_sync  <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            io0_sync  <= {io0_sync[0], spi_io_di[0]};
            sclk_d    <= sclk_sync[1];
            cs_d      <= cs_sync[1];
        end
    end

    logic rise;
    logic fall;
    logic cs_high;
    logic cs_fall;
    logic din;
    logic unused_io;

    assign rise      = sclk_sync[1] & ~sclk_d;
    assign fall      = ~sclk_sync[1] & sclk_d;
    assign cs_high   = cs_sync[1];
    assign cs_fall   = ~cs_sync[1] & cs_d;
    assign din       = io0_sync[1];
    assign unused_io = ^spi_io_di[3:1];

    state_t        state;
    lanes_t        lanes;
    logic          slow;
    logic [5:0]    bit_cnt;
    logic [AW-2:0] shreg;
    logic [AW-1:0] addr;
    logic [7:0]    cur;
    logic [7:0]    next_byte;
    logic [2:0]    unit_cnt;
    logic [1:0]    id_idx;
    logic          re_d;

    logic [AW-1:0] start_addr;
    logic [7:0]    byte_src;
    logic [2:0]    last_unit;
    logic [7:0]    jedec_byte;

    assign start_addr = {shreg, din};

    // A fetch can land on the very cycle its byte is needed, so bypass it.
    always_comb begin
        byte_src = cur;
        if (unit_cnt == 3'd0) begin
            byte_src = re_d ? mem_rdata : next_byte;
        end
        case (lanes)
            LANE_2:  last_unit = 3'd3;
            LANE_4:  last_unit = 3'd1;
            default: last_unit = 3'd7;
        endcase
        case (id_idx)
            2'd0:    jedec_byte = JEDEC_ID[23:16];
            2'd1:    jedec_byte = JEDEC_ID[15:8];
            default: jedec_byte = JEDEC_ID[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            lanes     <= LANE_1;
            slow      <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            addr      <= '0;
            cur       <= '0;
            next_byte <= '0;
            unit_cnt  <= '0;
            id_idx    <= '0;
            re_d      <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            spi_io_do <= '0;
            spi_io_oe <= '0;
        end else begin
            mem_re <= 1'b0;
            re_d   <= mem_re;
            if (re_d) begin
                next_byte <= mem_rdata;
            end
            if (cs_high) begin
                state     <= S_IDLE;
                spi_io_do <= '0;
                spi_io_oe <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cs_fall) begin
                            state   <= S_CMD;
                            bit_cnt <= '0;
                        end
                    end
                    S_CMD: begin
                        if (rise) begin
                            shreg   <= {shreg[AW-3:0], din};
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd7) begin
                                bit_cnt  <= '0;
                                unit_cnt <= '0;
                                lanes    <= LANE_1;
                                slow     <= 1'b0;
                                case ({shreg[6:0], din})
                                    8'h03: begin
                                        state <= S_ADDR;
                                        slow  <= 1'b1;
                                    end
                                    8'h0B: state <= S_ADDR;
                                    8'h3B: begin
                                        state <= S_ADDR;
                                        lanes <= LANE_2;
                                    end
                                    8'h6B: begin
                                        state <= S_ADDR;
                                        lanes <= LANE_4;
                                    end
                                    8'h9F: begin
                                        state     <= S_ID;
                                        next_byte <= JEDEC_ID[23:16];
                                        id_idx    <= 2'd1;
                                    end
                                    default: state <= S_IGNORE;
                                endcase
                            end
                        end
                    end
                    S_ADDR: begin
                        if (rise) begin
                            shreg   <= {shreg[AW-3:0], din};
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd23) begin
                                bit_cnt <= '0;
                                addr    <= start_addr;
                                if (slow || DUMMY == 0) begin
                                    state    <= S_DATA;
                                    mem_re   <= 1'b1;
                                    mem_addr <= start_addr;
                                    addr     <= start_addr + 1'b1;
                                end else begin
                                    state <= S_DUMMY;
                                end
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (rise) begin
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == DUMMY_LAST) begin
                                state    <= S_DATA;
                                mem_re   <= 1'b1;
                                mem_addr <= addr;
                                addr     <= addr + 1'b1;
                            end
                        end
                    end
                    S_DATA, S_ID: begin
                        if (fall) begin
                            unit_cnt <= (unit_cnt == last_unit) ? 3'd0 : unit_cnt + 3'd1;
                            case (lanes)
                                LANE_2: begin
                                    spi_io_do <= {2'b00, byte_src[7:6]};
                                    spi_io_oe <= 4'b0011;
                                    cur       <= {byte_src[5:0], 2'b00};
                                end
                                LANE_4: begin
                                    spi_io_do <= byte_src[7:4];
                                    spi_io_oe <= 4'b1111;
                                    cur       <= {byte_src[3:0], 4'b0000};
                                end
                                default: begin
                                    spi_io_do <= {2'b00, byte_src[7], 1'b0};
                                    spi_io_oe <= 4'b0010;
                                    cur       <= {byte_src[6:0], 1'b0};
                                end
                            endcase
                            // Each byte start prefetches the following byte.
                            if (unit_cnt == 3'd0) begin
                                if (state == S_DATA) begin
                                    mem_re   <= 1'b1;
                                    mem_addr <= addr;
                                    addr     <= addr + 1'b1;
                                end else begin
                                    next_byte <= jedec_byte;
                                    id_idx    <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
                                end
                            end
                        end
                    end
                    S_IGNORE: begin
                        spi_io_oe <= '0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flashemu_mio.sv
// Randomised SPI-master bench for flashemu_mio with a byte-array flash model
// and literal pins for the documented read, ID, wrap and reset scenarios.
module tb_flashemu_mio;

    localparam int          AW    = 16;
    localparam int          DUMMY = 8;
    localparam logic [23:0] JEDEC = 24'hEF4016;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          spi_clk  = 1'b0;
    logic          spi_cs_n = 1'b1;
    logic [3:0]    spi_io_di = 4'd0;
    logic [3:0]    spi_io_do;
    logic [3:0]    spi_io_oe;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;

    logic [7:0]    mem [0:(1<<AW)-1];
    logic [AW-1:0] fetch_q [$];
    int            checks = 0;
    int            errors = 0;
    logic          re_prev = 1'b0;

    always #5 clk = ~clk;

    flashemu_mio #(
        .AW      (AW),
        .DUMMY   (DUMMY),
        .JEDEC_ID(JEDEC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .spi_clk  (spi_clk),
        .spi_cs_n (spi_cs_n),
        .spi_io_di(spi_io_di),
        .spi_io_do(spi_io_do),
        .spi_io_oe(spi_io_oe),
        .mem_re   (mem_re),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata)
    );

    // Memory answers one clk after the strobe; other cycles carry garbage.
    always @(posedge clk) mem_rdata <= mem_re ? mem[mem_addr] : 8'($urandom);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mem_re) begin
            fetch_q.push_back(mem_addr);
            checkOutput("mem_re_single_pulse", {31'd0, re_prev}, 32'd0);
        end
        re_prev = mem_re;
    end

    function automatic int kindOf(input logic [7:0] cmd);
        case (cmd)
            8'h03, 8'h0B, 8'h3B, 8'h6B: return 1;
            8'h9F:                      return 2;
            default:                    return 0;
        endcase
    endfunction

    function automatic int lanesOf(input logic [7:0] cmd);
        case (cmd)
            8'h3B:   return 2;
            8'h6B:   return 4;
            default: return 1;
        endcase
    endfunction

    // Unit u of the output stream: bit offset u*w into the byte stream.
    function automatic logic [3:0] modelUnit(input int kind, input int w, input logic [AW-1:0] start, input int u);
        int         bitpos;
        int         idx;
        int         off;
        logic [7:0] b;
        bitpos = u * w;
        idx    = bitpos / 8;
        off    = bitpos % 8;
        if (kind == 2) b = 8'(JEDEC >> (8 * (2 - idx % 3)));
        else           b = mem[AW'(int'(start) + idx)];
        return 4'((int'(b) >> (8 - off - w)) & ((1 << w) - 1));
    endfunction

    function automatic logic frameBit(input logic [7:0] cmd, input logic [23:0] a, input int i);
        if (i < 8)  return cmd[7 - i];
        if (i < 32) return a[31 - i];
        return 1'($urandom);
    endfunction

    task automatic spiClock(input logic din, output logic [3:0] d, output logic [3:0] o);
        spi_io_di = {3'($urandom), din};
        repeat ($urandom_range(2, 3)) @(posedge clk);
        #1 spi_clk = 1'b1;
        repeat ($urandom_range(2, 4)) @(posedge clk);
        #1 spi_clk = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        d = spi_io_do;
        o = spi_io_oe;
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input logic [23:0] a, input int nunits,
                                 output logic [63:0] got);
        int            kind;
        int            w;
        int            npre;
        int            nfetch;
        int            u;
        logic [AW-1:0] start;
        logic [3:0]    d;
        logic [3:0]    o;
        logic [3:0]    ev;
        logic [3:0]    exp_do;
        logic [3:0]    exp_oe;
        kind  = kindOf(cmd);
        w     = lanesOf(cmd);
        start = a[AW-1:0];
        npre  = 8 + ((kind == 1) ? 24 : 0) + ((kind == 1 && cmd != 8'h03) ? DUMMY : 0);
        got   = '0;
        fetch_q.delete();
        spi_cs_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < npre + nunits - 1; i++) begin
            spiClock(frameBit(cmd, a, i), d, o);
            if (kind == 0 || i < npre - 1) begin
                checkOutput("idle_oe", {28'd0, o}, 32'd0);
            end else begin
                u      = i - (npre - 1);
                ev     = modelUnit(kind, w, start, u);
                exp_do = (w == 1) ? {2'b00, ev[0], 1'b0} : ev;
                exp_oe = (w == 1) ? 4'b0010 : ((w == 2) ? 4'b0011 : 4'b1111);
                checkOutput("data_do", {28'd0, d}, {28'd0, exp_do});
                checkOutput("data_oe", {28'd0, o}, {28'd0, exp_oe});
                got = (got << w) | 64'((w == 1) ? {3'd0, d[1]} : ((w == 2) ? {2'd0, d[1:0]} : d));
            end
        end
        spi_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("cs_release_oe", {28'd0, spi_io_oe}, 32'd0);
        repeat (4) @(posedge clk);
        nfetch = (kind == 1) ? 1 + (nunits * w + 7) / 8 : 0;
        checkOutput("fetch_count", fetch_q.size(), nfetch);
        for (int i = 0; i < fetch_q.size() && i < nfetch; i++) begin
            checkOutput("fetch_addr", {16'd0, fetch_q[i]}, {16'd0, AW'(int'(start) + i)});
        end
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] got;
        logic [3:0]  d;
        logic [3:0]  o;
        logic [7:0]  rcmd;

        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        mem[16'h0004] = 8'h04; mem[16'h0005] = 8'h05;
        mem[16'h0006] = 8'h06; mem[16'h0007] = 8'h07;
        mem[16'h1000] = 8'hA5; mem[16'h1001] = 8'h3C;
        mem[16'h0010] = 8'hB4;
        mem[16'hFFFF] = 8'h96; mem[16'h0000] = 8'h5A;
        mem[16'h0020] = 8'hC7; mem[16'h0021] = 8'h19;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_oe", {28'd0, spi_io_oe}, 32'd0);
        checkOutput("reset_do", {28'd0, spi_io_do}, 32'd0);
        checkOutput("reset_mem_re", {31'd0, mem_re}, 32'd0);
        checkOutput("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        applyStimulus(8'h03, 24'h000004, 32, got);
        checkOutput("single_read_io1", got[31:0], 32'h04050607);
        checkOutput("single_last_fetch", (fetch_q.size() == 5) ? {16'd0, fetch_q[4]} : 32'hDEAD, 32'h8);

        applyStimulus(8'h6B, 24'h001000, 4, got);
        checkOutput("quad_read", {16'd0, got[15:0]}, 32'hA53C);

        applyStimulus(8'h3B, 24'h000010, 4, got);
        checkOutput("dual_read", {24'd0, got[7:0]}, 32'hB4);

        applyStimulus(8'h9F, 24'h000000, 32, got);
        checkOutput("jedec_id", got[31:0], 32'hEF4016EF);
        applyStimulus(8'hFF, 24'h000000, 16, got);
        applyStimulus(8'hAB, 24'h000000, 16, got);

        applyStimulus(8'h03, 24'h00FFFF, 11, got);
        checkOutput("wrap_fetch0", (fetch_q.size() >= 2) ? {16'd0, fetch_q[0]} : 32'hDEAD, 32'hFFFF);
        checkOutput("wrap_fetch1", (fetch_q.size() >= 2) ? {16'd0, fetch_q[1]} : 32'hDEAD, 32'h0000);
        checkOutput("wrap_bits", {21'd0, got[10:0]}, {21'd0, 8'h96, 3'b010});
        applyStimulus(8'h03, 24'h000000, 8, got);
        checkOutput("read_after_abort", {24'd0, got[7:0]}, 32'h5A);

        fetch_q.delete();
        spi_cs_n = 1'b0;
        repeat (6) @(posedge clk);
        spi_cs_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("empty_frame_oe", {28'd0, spi_io_oe}, 32'd0);
        checkOutput("empty_frame_fetch", fetch_q.size(), 0);

        spi_cs_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        o = '0;
        for (int i = 0; i < 8 + 24 + DUMMY + 3; i++) spiClock(frameBit(8'h6B, 24'h001000, i), d, o);
        checkOutput("quad_oe_before_reset", {28'd0, o}, 32'hF);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_oe", {28'd0, spi_io_oe}, 32'd0);
        checkOutput("async_reset_do", {28'd0, spi_io_do}, 32'd0);
        checkOutput("async_reset_mem_re", {31'd0, mem_re}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        fetch_q.delete();
        for (int i = 0; i < 16; i++) begin
            spiClock(frameBit(8'h03, 24'h000020, i), d, o);
            checkOutput("post_reset_ignored_oe", {28'd0, o}, 32'd0);
        end
        spi_cs_n = 1'b1;
        repeat (6) @(posedge clk);
        checkOutput("post_reset_no_fetch", fetch_q.size(), 0);
        applyStimulus(8'h03, 24'h000020, 16, got);
        checkOutput("post_reset_read", {16'd0, got[15:0]}, 32'hC719);

        for (int n = 0; n < 16; n++) begin
            case ($urandom_range(0, 7))
                0: rcmd = 8'h03;
                1: rcmd = 8'h0B;
                2: rcmd = 8'h3B;
                3: rcmd = 8'h6B;
                4: rcmd = 8'h9F;
                5: rcmd = 8'hFF;
                6: rcmd = 8'hAB;
                default: rcmd = 8'($urandom);
            endcase
            applyStimulus(rcmd, 24'($urandom), $urandom_range(1, 24), got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
